tc_multi: RTL and testbench

- Multi-channel memory-mapped timer/counter; successor to the single-channel TC bridge device.
- N_CH independent down-counters, each with per-channel programmable width, mode, optional prescaler and a sticky interrupt-pending bit.
- Sits on the CPU bridge next to the other peripherals; the single IRQ output feeds the CP0 hardware-interrupt line.

---
 rtl/tc_pkg.sv | 25 ++
 rtl/tc_multi_if.sv | 12 +
 rtl/tc_channel.sv | 134 +++++++++++++
 rtl/tc_multi.sv | 49 ++++
 tb/tb_tc_multi.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the multi-channel timer/counter: FSM encodings,
// register offsets, CTRL bit positions and mode codes.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PSC_LO  = 8;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

endpackage

// File: rtl/tc_multi_if.sv
// CPU bridge view of the timer block: word address, write strobe/data,
// combinational read data and the interrupt line.
interface tc_multi_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers and the
// IDLE/LOAD/CNT/INT sequencer; prescaler present only with TC_PRESCALE_EN.
module tc_channel import tc_pkg::*; #(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] din,
    output logic [31:0] rd_data,
    output logic        irq
);

    logic             en;
    logic             im;
    logic             pend;
    logic [1:0]       mode;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    tc_state_e        state;
    logic             tick;
    logic             freeze;
    logic             clear;
    logic             one_shot;

`ifdef TC_PRESCALE_EN
    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] psc_cnt;
    assign tick = (psc_cnt == psc);
`else
    assign tick = 1'b1;
`endif

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(1)) ? v - CNT_W'(1) : '0;
    endfunction

    // STATUS writes only touch pend, so they leave the sequencer running
    // and an expiry in the same cycle can still set pend afterwards.
    assign freeze   = sel && we && (reg_sel != REG_STATUS);
    assign clear    = sel && we && (reg_sel == REG_STATUS) && din[0];
    assign one_shot = (mode != MODE_PERIODIC);
    assign irq      = pend & im;

    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= 1'b0;
            im      <= 1'b0;
            mode    <= MODE_ONESHOT;
            pend    <= 1'b0;
            preset  <= '0;
            count   <= '0;
            state   <= IDLE;
`ifdef TC_PRESCALE_EN
            psc     <= '0;
            psc_cnt <= '0;
`endif
        end else begin
            if (sel && we) begin
                case (reg_sel)
                    REG_CTRL: begin
                        en   <= din[CTRL_EN];
                        mode <= din[CTRL_MODE_LO +: 2];
                        im   <= din[CTRL_IM];
`ifdef TC_PRESCALE_EN
                        psc  <= din[CTRL_PSC_LO +: PSC_W];
`endif
                    end
                    REG_PRESET: preset <= din[CNT_W-1:0];
                    default: ;
                endcase
            end

            if (clear)
                pend <= 1'b0;

            if (!freeze) begin
                unique case (state)
                    IDLE: if (en) state <= LOAD;
                    LOAD: begin
                        count   <= preset;
`ifdef TC_PRESCALE_EN
                        psc_cnt <= '0;
`endif
                        state   <= CNT;
                    end
                    CNT: begin
                        if (!en) begin
                            state <= IDLE;
                        end else if (tick) begin
                            count <= dec_sat(count);
                            if (count <= CNT_W'(1)) begin
                                pend  <= 1'b1;
                                state <= INT;
                            end
`ifdef TC_PRESCALE_EN
                            psc_cnt <= '0;
                        end else begin
                            psc_cnt <= psc_cnt + PSC_W'(1);
`endif
                        end
                    end
                    INT: begin
                        if (one_shot)
                            en <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_EN]           = en;
                rd_data[CTRL_MODE_LO +: 2] = mode;
                rd_data[CTRL_IM]           = im;
`ifdef TC_PRESCALE_EN
                rd_data[CTRL_PSC_LO +: PSC_W] = psc;
`endif
            end
            REG_PRESET: rd_data[CNT_W-1:0] = preset;
            REG_COUNT:  rd_data[CNT_W-1:0] = count;
            REG_STATUS: rd_data[0]         = pend;
            default: ;
        endcase
    end

endmodule

// File: rtl/tc_multi.sv
// Multi-channel timer/counter on the CPU bridge: address decode, read mux
// and IRQ reduction over N_CH tc_channel instances (prescaler: TC_PRESCALE_EN).
module tc_multi import tc_pkg::*; #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    tc_multi_if.slave  bus
);

    logic [2:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] ch_rd [N_CH];
    logic [N_CH-1:0] ch_irq;
    logic        unused_addr;

    assign ch_sel      = bus.Addr[6:4];
    assign reg_sel     = bus.Addr[3:2];
    assign unused_addr = ^bus.Addr[31:7];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tc_channel #(
            .CNT_W (CNT_W),
            .PSC_W (PSC_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .sel     (ch_sel == 3'(i)),
            .we      (bus.WE),
            .reg_sel (reg_sel),
            .din     (bus.Din),
            .rd_data (ch_rd[i]),
            .irq     (ch_irq[i])
        );
    end

    // Channel indices with no instance fall through to zero.
    always_comb begin
        bus.Dout = '0;
        for (int i = 0; i < N_CH; i++)
            if (ch_sel == 3'(i))
                bus.Dout = ch_rd[i];
    end

    assign bus.IRQ = |ch_irq;

endmodule

// File: tb/tb_tc_multi.sv
// Scoreboard bench for tc_multi: directed timing scenarios plus randomized
// channel programs checked against a closed-form timing model.
module tb_tc_multi;
    localparam int N_CH  = 2;
    localparam int CNT_W = 16;
    localparam int PSC_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tc_multi_if bus ();

    tc_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_vld = 1'b0;

    // Monitor: whenever a read is presented, pop its expectation and compare.
    initial begin
        exp_t        it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            #1;
            if (rd_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL monitor: read at cycle %0d with no expectation", cyc);
                end else begin
                    it  = exp_q.pop_front();
                    act = bus.Dout;
                    checks++;
                    if (act !== it.dout) begin
                        errors++;
                        $display("FAIL %s: Dout=0x%08h expected 0x%08h (cycle %0d)", it.name, act, it.dout, cyc);
                    end
                    checks++;
                    if (bus.IRQ !== it.irq) begin
                        errors++;
                        $display("FAIL %s_irq: IRQ=%0b expected %0b (cycle %0d)", it.name, bus.IRQ, it.irq, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:2] addr(input int ch, input int r);
        logic [31:2] a;
        a      = '0;
        a[6:4] = 3'(ch);
        a[3:2] = 2'(r);
        return a;
    endfunction

    // Wait for the falling edge that follows rising edge number e.
    task automatic at_neg(input int e);
        @(negedge clk);
        for (int k = 0; k < 50000 && cyc < e; k++) @(negedge clk);
        if (cyc != e) begin
            checks++;
            errors++;
            $display("FAIL schedule: reached cycle %0d, wanted %0d", cyc, e);
        end
    endtask

    task automatic drive_wr(input int ch, input int r, input logic [31:0] d, output int t);
        bus.Addr = addr(ch, r);
        bus.Din  = d;
        bus.WE   = 1'b1;
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
        t = cyc;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d, output int t);
        @(negedge clk);
        drive_wr(ch, r, d, t);
    endtask

    task automatic wr_at(input int e, input int ch, input int r, input logic [31:0] d);
        int t;
        at_neg(e - 1);
        drive_wr(ch, r, d, t);
    endtask

    task automatic rd_now(input int ch, input int r, input logic [31:0] x, input logic xi, input string n);
        exp_t it;
        bus.Addr = addr(ch, r);
        bus.WE   = 1'b0;
        it.name  = n;
        it.dout  = x;
        it.irq   = xi;
        exp_q.push_back(it);
        rd_vld = 1'b1;
        #2;
        rd_vld = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, input logic [31:0] x, input logic xi, input string n);
        @(negedge clk);
        rd_now(ch, r, x, xi, n);
    endtask

    task automatic rd_at(input int e, input int ch, input int r, input logic [31:0] x, input logic xi, input string n);
        at_neg(e);
        rd_now(ch, r, x, xi, n);
    endtask

    // COUNT after edge e, given CNT was first entered at edge s0 holding P.
    // Each tick costs psc+1 cycles; periodic reload takes 3 cycles after expiry.
    function automatic int model_count(input int e, input int s0, input int p, input int psc,
                                       input int per, input bit periodic);
        int s;
        s = s0;
        while (e >= s + per) begin
            if (!periodic || e < s + per + 3) return 0;
            s = s + per + 3;
        end
        return p - (e - s) / (psc + 1);
    endfunction

    task automatic run_trial();
        int ch, p, psc, psc_w, mode, im, t, per, e1, last, pick, x;
        bit periodic, pend, en;
        logic [31:0] ctrl;
        ch = $urandom_range(0, N_CH - 1);
        p  = $urandom_range(0, 12);
`ifdef TC_PRESCALE_EN
        psc   = $urandom_range(0, 3);
        psc_w = psc;
`else
        psc   = 0;
        psc_w = $urandom_range(0, 255);
`endif
        mode     = $urandom_range(0, 3);
        im       = $urandom_range(0, 1);
        periodic = (mode == 1);
        ctrl     = (32'(psc_w) << 8) | (32'(im) << 3) | (32'(mode) << 1) | 32'd1;
        wr(ch, 1, 32'(p), t);
        wr(ch, 0, ctrl, t);
        per  = ((p == 0) ? 1 : p) * (psc + 1);
        e1   = t + 2 + per;
        last = periodic ? e1 + 2 * (per + 3) + 2 : e1 + 3;
        for (int e = t; e <= last; e++) begin
            pend = (e >= e1);
            en   = !(!periodic && e >= e1 + 1);
            pick = $urandom_range(0, 2);
            if (pick == 0 && e >= t + 2) begin
                x = model_count(e, t + 2, p, psc, per, periodic);
                rd(ch, 2, 32'(x), pend & im[0], "rand_count");
            end else if (pick == 2) begin
                rd(ch, 0, (32'(psc) << 8) | (32'(im) << 3) | (32'(mode) << 1) | 32'(en),
                   pend & im[0], "rand_ctrl");
            end else begin
                rd(ch, 3, 32'(pend), pend & im[0], "rand_status");
            end
        end
        wr(ch, 0, 32'd0, t);
        for (int k = 0; k < 4; k++) rd(ch, 0, 32'd0, 1'b0, "rand_disable");
        wr(ch, 3, 32'd1, t);
        rd(ch, 3, 32'd0, 1'b0, "rand_clear");
    endtask

    initial begin
        int t, r;
        bus.Addr = '0;
        bus.WE   = 1'b0;
        bus.Din  = '0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, unimplemented channels
        for (int ch = 0; ch < 2; ch++)
            for (int rg = 0; rg < 4; rg++)
                rd(ch, rg, 32'd0, 1'b0, "reset_reg");
        rd(2, 0, 32'd0, 1'b0, "oor_ctrl");
        rd(7, 1, 32'd0, 1'b0, "oor_preset");
        wr(5, 1, 32'h1234, t);
        rd(5, 1, 32'd0, 1'b0, "oor_write");
        rd(0, 1, 32'd0, 1'b0, "oor_no_alias0");
        rd(1, 1, 32'd0, 1'b0, "oor_no_alias1");

        // One-shot, PRESET 5: pend 7 edges after the enabling write
        wr(0, 1, 32'd5, t);
        wr(0, 0, 32'h9, t);
        for (int k = 0; k <= 7; k++)
            rd(0, 3, (k == 7) ? 32'd1 : 32'd0, (k == 7), "oneshot_pend");
        rd(0, 0, 32'h8, 1'b1, "oneshot_ctrl");
        rd(0, 2, 32'd0, 1'b1, "oneshot_count");
        wr(0, 3, 32'd1, t);
        rd(0, 3, 32'd0, 1'b0, "oneshot_clear");

        // Periodic, PRESET 3: expiries every 6 cycles from t+5
        wr(1, 1, 32'd3, t);
        wr(1, 0, 32'hB, t);
        rd_at(t + 4,  1, 3, 32'd0, 1'b0, "per_before1");
        rd_at(t + 5,  1, 3, 32'd1, 1'b1, "per_exp1");
        wr_at(t + 8,  1, 3, 32'd1);
        rd_at(t + 8,  1, 3, 32'd0, 1'b0, "per_clr1");
        rd_at(t + 10, 1, 3, 32'd0, 1'b0, "per_before2");
        rd_at(t + 11, 1, 3, 32'd1, 1'b1, "per_exp2");
        wr_at(t + 17, 1, 3, 32'd1);
        rd_at(t + 17, 1, 3, 32'd1, 1'b1, "clear_vs_expiry");
        wr_at(t + 19, 1, 3, 32'd1);
        rd_at(t + 19, 1, 3, 32'd0, 1'b0, "per_clr3");
        rd_at(t + 22, 1, 3, 32'd0, 1'b0, "per_before4");
        rd_at(t + 23, 1, 3, 32'd1, 1'b1, "per_exp4");
        rd_at(t + 24, 1, 2, 32'd0, 1'b1, "per_count_zero");
        rd_at(t + 26, 1, 2, 32'd3, 1'b1, "per_reload");
        wr(1, 0, 32'd0, t);
        repeat (3) @(negedge clk);
        wr(1, 3, 32'd1, t);
        rd(1, 3, 32'd0, 1'b0, "per_stopped");

        // Disable mid-count holds COUNT; re-enable reloads
        wr(0, 1, 32'd100, t);
        wr(0, 0, 32'h1, t);
        rd_at(t + 51, 0, 2, 32'd51, 1'b0, "hold_pre");
        wr_at(t + 53, 0, 0, 32'd0);
        rd_at(t + 53, 0, 2, 32'd50, 1'b0, "hold_freeze");
        rd_at(t + 54, 0, 2, 32'd50, 1'b0, "hold_idle");
        rd_at(t + 60, 0, 2, 32'd50, 1'b0, "hold_later");
        rd_at(t + 61, 0, 3, 32'd0, 1'b0, "hold_nopend");
        wr(0, 0, 32'h1, r);
        rd_at(r + 1, 0, 2, 32'd50, 1'b0, "reload_load");
        rd_at(r + 2, 0, 2, 32'd100, 1'b0, "reload_100");
        rd_at(r + 3, 0, 2, 32'd99, 1'b0, "reload_99");
        wr(0, 0, 32'd0, t);
        repeat (3) @(negedge clk);

        // Prescaler field
        wr(0, 1, 32'd2, t);
        wr(0, 0, 32'h309, t);
`ifdef TC_PRESCALE_EN
        rd_at(t + 1,  0, 0, 32'h309, 1'b0, "psc_ctrl");
        rd_at(t + 9,  0, 3, 32'd0, 1'b0, "psc_before");
        rd_at(t + 10, 0, 3, 32'd1, 1'b1, "psc_expiry");
`else
        rd_at(t + 1, 0, 0, 32'h9, 1'b0, "psc_ctrl");
        rd_at(t + 3, 0, 3, 32'd0, 1'b0, "psc_before");
        rd_at(t + 4, 0, 3, 32'd1, 1'b1, "psc_expiry");
`endif
        wr(0, 0, 32'd0, t);
        wr(0, 3, 32'd1, t);
        rd(0, 3, 32'd0, 1'b0, "psc_clear");

        // Writes to ch1 do not disturb ch0 timing; PRESET truncation
        wr(0, 1, 32'd4, t);
        wr(0, 0, 32'h1, t);
        wr_at(t + 2, 1, 1, $urandom);
        rd_at(t + 2, 0, 3, 32'd0, 1'b0, "iso_before1");
        wr_at(t + 4, 1, 1, $urandom);
        rd_at(t + 4, 0, 3, 32'd0, 1'b0, "iso_before2");
        wr_at(t + 6, 1, 1, 32'hFFFF_FFFF);
        rd_at(t + 6, 0, 3, 32'd1, 1'b0, "iso_expiry_noim");
        rd(1, 1, 32'h0000_FFFF, 1'b0, "preset_trunc");
        wr(0, 3, 32'd1, t);

        for (int n = 0; n < 16; n++) run_trial();

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never checked", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
